// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and ALU opcode constants for the alu_arb slice.
// Also provides default values for the `DATA_WIDTH / `ARGS_WIDTH / `DATA_ZERO
// macros when the surrounding codebase has not already defined them.
// Optional feature macro used by alu_arb: ALU_ARB_RR_EN (round-robin grant).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 4
`endif
`ifndef DATA_ZERO
`define DATA_ZERO {`DATA_WIDTH{1'b0}}
`endif

package alu_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  // Requester id: 0 = EXU issue, 1 = address generation.
  typedef logic req_id_t;

  localparam int unsigned SHAMT_W = $clog2(`DATA_WIDTH);

  localparam logic [`ARGS_WIDTH-1:0] ALU_ADD  = `ARGS_WIDTH'(0);
  localparam logic [`ARGS_WIDTH-1:0] ALU_SUB  = `ARGS_WIDTH'(1);
  localparam logic [`ARGS_WIDTH-1:0] ALU_AND  = `ARGS_WIDTH'(2);
  localparam logic [`ARGS_WIDTH-1:0] ALU_OR   = `ARGS_WIDTH'(3);
  localparam logic [`ARGS_WIDTH-1:0] ALU_XOR  = `ARGS_WIDTH'(4);
  localparam logic [`ARGS_WIDTH-1:0] ALU_SLL  = `ARGS_WIDTH'(5);
  localparam logic [`ARGS_WIDTH-1:0] ALU_SRL  = `ARGS_WIDTH'(6);
  localparam logic [`ARGS_WIDTH-1:0] ALU_SRA  = `ARGS_WIDTH'(7);
  localparam logic [`ARGS_WIDTH-1:0] ALU_SLT  = `ARGS_WIDTH'(8);
  localparam logic [`ARGS_WIDTH-1:0] ALU_SLTU = `ARGS_WIDTH'(9);

endpackage

// File: rtl/alu_arb_alu.sv
// alu_arb_alu: the shared combinational ALU. Unknown opcodes yield zero.
module alu_arb_alu
  import alu_arb_pkg::*;
(
  input  logic [`ARGS_WIDTH-1:0] alu_type_i,
  input  logic [`DATA_WIDTH-1:0] rs1_i,
  input  logic [`DATA_WIDTH-1:0] rs2_i,
  output logic [`DATA_WIDTH-1:0] res_o
);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = rs2_i[SHAMT_W-1:0];

  // Opcode decode and result select.
  always_comb begin
    res_o = `DATA_ZERO;
    unique case (alu_type_i)
      ALU_ADD:  res_o = rs1_i + rs2_i;
      ALU_SUB:  res_o = rs1_i - rs2_i;
      ALU_AND:  res_o = rs1_i & rs2_i;
      ALU_OR:   res_o = rs1_i | rs2_i;
      ALU_XOR:  res_o = rs1_i ^ rs2_i;
      ALU_SLL:  res_o = rs1_i << shamt;
      ALU_SRL:  res_o = rs1_i >> shamt;
      ALU_SRA:  res_o = $unsigned($signed(rs1_i) >>> shamt);
      ALU_SLT:  res_o = {{(`DATA_WIDTH-1){1'b0}}, ($signed(rs1_i) < $signed(rs2_i))};
      ALU_SLTU: res_o = {{(`DATA_WIDTH-1){1'b0}}, (rs1_i < rs2_i)};
      default:  res_o = `DATA_ZERO;
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// alu_arb: two requesters share one ALU; the result is held in a single
// response register tagged with its owner until the owner accepts it.
// Define ALU_ARB_RR_EN for round-robin contention; default is fixed
// priority with requester 0 winning.
module alu_arb
  import alu_arb_pkg::*;
(
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   i_req0_valid,
  output logic                   o_req0_ready,
  input  logic [`ARGS_WIDTH-1:0] i_req0_alu_type,
  input  logic [`DATA_WIDTH-1:0] i_req0_rs1_data,
  input  logic [`DATA_WIDTH-1:0] i_req0_rs2_data,
  input  logic                   i_req1_valid,
  output logic                   o_req1_ready,
  input  logic [`ARGS_WIDTH-1:0] i_req1_alu_type,
  input  logic [`DATA_WIDTH-1:0] i_req1_rs1_data,
  input  logic [`DATA_WIDTH-1:0] i_req1_rs2_data,
  output logic                   o_rsp0_valid,
  input  logic                   i_rsp0_ready,
  output logic [`DATA_WIDTH-1:0] o_rsp0_res,
  output logic                   o_rsp1_valid,
  input  logic                   i_rsp1_ready,
  output logic [`DATA_WIDTH-1:0] o_rsp1_res,
  output logic                   o_arb_busy
);

  arb_state_e             state_q, state_d;
  req_id_t                owner_q;
  logic [`DATA_WIDTH-1:0] res_q;
  req_id_t                grant;
  logic                   rsp_hs, can_issue, accept;
  logic [`ARGS_WIDTH-1:0] alu_type;
  logic [`DATA_WIDTH-1:0] alu_rs1, alu_rs2, alu_res;

  // Owner-side response handshake; the non-owner's ready is ignored.
  assign rsp_hs    = (state_q == ST_HOLD) &&
                     (owner_q ? i_rsp1_ready : i_rsp0_ready);
  assign can_issue = (state_q == ST_IDLE) || rsp_hs;
  assign accept    = can_issue && (grant ? i_req1_valid : i_req0_valid);

`ifdef ALU_ARB_RR_EN
  req_id_t last_q;

  // Last-grant pointer; reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst)   last_q <= 1'b1;
    else if (accept) last_q <= grant;
  end
`endif

  // Grant selection: single valid requester wins, contention per policy.
  always_comb begin
    grant = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
`ifdef ALU_ARB_RR_EN
      grant = ~last_q;
`else
      grant = 1'b0;
`endif
    end else if (i_req1_valid) begin
      grant = 1'b1;
    end
  end

  // Operand mux into the single shared ALU.
  always_comb begin
    alu_type = grant ? i_req1_alu_type : i_req0_alu_type;
    alu_rs1  = grant ? i_req1_rs1_data : i_req0_rs1_data;
    alu_rs2  = grant ? i_req1_rs2_data : i_req0_rs2_data;
  end

  alu_arb_alu u_alu (
    .alu_type_i (alu_type),
    .rs1_i      (alu_rs1),
    .rs2_i      (alu_rs2),
    .res_o      (alu_res)
  );

  // State register.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next state: any accept lands in HOLD (also back-to-back), release -> IDLE.
  always_comb begin
    state_d = state_q;
    if (accept)      state_d = ST_HOLD;
    else if (rsp_hs) state_d = ST_IDLE;
  end

  // Response register and owner tag; cleared on release so res reads zero.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      res_q   <= `DATA_ZERO;
      owner_q <= 1'b0;
    end else if (accept) begin
      res_q   <= alu_res;
      owner_q <= grant;
    end else if (rsp_hs) begin
      res_q   <= `DATA_ZERO;
    end
  end

  // Outputs: ready to the granted requester only, response to the owner only.
  always_comb begin
    o_req0_ready = can_issue && (grant == 1'b0);
    o_req1_ready = can_issue && (grant == 1'b1);
    o_rsp0_valid = (state_q == ST_HOLD) && (owner_q == 1'b0);
    o_rsp1_valid = (state_q == ST_HOLD) && (owner_q == 1'b1);
    o_rsp0_res   = o_rsp0_valid ? res_q : `DATA_ZERO;
    o_rsp1_res   = o_rsp1_valid ? res_q : `DATA_ZERO;
    o_arb_busy   = (state_q == ST_HOLD);
  end

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed scenarios plus randomized traffic checked against a
// transaction-level model (pending-result queue + arithmetic ALU reference).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 4
`endif

module tb_alu_arb;

  localparam int W = `DATA_WIDTH;
  localparam int A = `ARGS_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         v0, v1, r0_rdy, r1_rdy;
  logic [A-1:0] t0, t1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         q0_rdy, q1_rdy, s0_v, s1_v, busy;
  logic [W-1:0] s0_res, s1_res;

  always #5 clk = ~clk;

  alu_arb dut (
    .i_sys_clk       (clk),
    .i_sys_rst       (rst),
    .i_req0_valid    (v0),
    .o_req0_ready    (q0_rdy),
    .i_req0_alu_type (t0),
    .i_req0_rs1_data (a0),
    .i_req0_rs2_data (b0),
    .i_req1_valid    (v1),
    .o_req1_ready    (q1_rdy),
    .i_req1_alu_type (t1),
    .i_req1_rs1_data (a1),
    .i_req1_rs2_data (b1),
    .o_rsp0_valid    (s0_v),
    .i_rsp0_ready    (r0_rdy),
    .o_rsp0_res      (s0_res),
    .o_rsp1_valid    (s1_v),
    .i_rsp1_ready    (r1_rdy),
    .o_rsp1_res      (s1_res),
    .o_arb_busy      (busy)
  );

  typedef struct {
    bit           owner;
    logic [W-1:0] res;
  } pend_t;

  pend_t       pend_q[$];
  bit          last_g = 1'b1;
  int unsigned n_chk  = 0;
  int unsigned n_err  = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference ALU from the opcode table, plain arithmetic.
  function automatic logic [W-1:0] alu_ref(input logic [A-1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned sh;
    sh = y % W;
    case (op)
      0: return x + y;
      1: return x - y;
      2: return x & y;
      3: return x | y;
      4: return x ^ y;
      5: return x << sh;
      6: return x >> sh;
      7: return $unsigned($signed(x) >>> sh);
      8: return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      9: return (x < y) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  // Who would win with the current valids under the configured policy.
  function automatic bit winner();
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return !last_g;
`else
      return 1'b0;
`endif
    end
    return v1;
  endfunction

  // One clock: compare outputs against the model mid-cycle, then advance it.
  task automatic tick();
    bit           pend, own, hs, free, g;
    logic [W-1:0] pres;
    @(negedge clk);
    pend = (pend_q.size() != 0);
    own  = pend ? pend_q[0].owner : 1'b0;
    pres = pend ? pend_q[0].res : '0;
    hs   = pend && (own ? r1_rdy : r0_rdy);
    free = !pend || hs;
    g    = winner();
    check("busy",       W'(busy),   W'(pend));
    check("rsp0_valid", W'(s0_v),   W'(pend && !own));
    check("rsp1_valid", W'(s1_v),   W'(pend && own));
    check("rsp0_res",   s0_res,     (pend && !own) ? pres : '0);
    check("rsp1_res",   s1_res,     (pend && own) ? pres : '0);
    check("req0_ready", W'(q0_rdy), W'(free && !g));
    check("req1_ready", W'(q1_rdy), W'(free && g));
    if (rst) begin
      pend_q.delete();
      last_g = 1'b1;
    end else begin
      if (hs) void'(pend_q.pop_front());
      if (free && (g ? v1 : v0)) begin
        pend_q.push_back('{owner: g, res: g ? alu_ref(t1, a1, b1) : alu_ref(t0, a0, b0)});
        last_g = g;
      end
    end
    if (pend_q.size() > 1) check("single_pending", W'(pend_q.size()), W'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v0 = 0; v1 = 0; r0_rdy = 0; r1_rdy = 0;
    t0 = '0; t1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    check("rst_busy", W'(busy), W'(0));
    check("rst_rsp0_valid", W'(s0_v), W'(0));
    check("rst_rsp1_res", s1_res, W'(0));

    // req0 ADD 5+3, result one cycle later.
    v0 = 1; t0 = A'(0); a0 = W'(5); b0 = W'(3); r0_rdy = 1;
    tick();
    v0 = 0;
    check("add_valid", W'(s0_v), W'(1));
    check("add_res", s0_res, W'(32'h8));
    check("add_rsp1_valid", W'(s1_v), W'(0));
    tick();

    // req1 SUB 0x10-0x01 held for 3 cycles while both requesters wait.
    v1 = 1; t1 = A'(1); a1 = W'(16); b1 = W'(1); r1_rdy = 0; r0_rdy = 0;
    tick();
    v0 = 1; a0 = W'(7); b0 = W'(9); t0 = A'(2);
    for (int unsigned i = 0; i < 3; i++) begin
      check("hold_res", s1_res, W'(32'hF));
      check("hold_req0_ready", W'(q0_rdy), W'(0));
      check("hold_req1_ready", W'(q1_rdy), W'(0));
      check("hold_busy", W'(busy), W'(1));
      tick();
    end
    r1_rdy = 1;
    #1;
    check("release_ready", W'(q0_rdy | q1_rdy), W'(1));
    tick();
    v0 = 0; v1 = 0;
    r0_rdy = 1; r1_rdy = 1;
    tick();
    tick();

    // Owner req1, non-owner ready pulsed: no handshake.
    r0_rdy = 0; r1_rdy = 0;
    v1 = 1; t1 = A'(0); a1 = W'(2); b1 = W'(3);
    tick();
    v1 = 0; r0_rdy = 1;
    tick();
    check("nonowner_valid", W'(s1_v), W'(1));
    check("nonowner_res", s1_res, W'(5));
    r0_rdy = 0; r1_rdy = 1;
    tick();

    // Reset mid-HOLD, then contended requests from a fresh pointer.
    r0_rdy = 0; r1_rdy = 0;
    v0 = 1; t0 = A'(3); a0 = W'(32'hF0); b0 = W'(32'h0F);
    tick();
    v0 = 0; rst = 1;
    tick();
    rst = 0;
    check("rstmid_busy", W'(busy), W'(0));
    check("rstmid_rsp0_valid", W'(s0_v), W'(0));
    check("rstmid_rsp0_res", s0_res, W'(0));
    v0 = 1; v1 = 1; r0_rdy = 1; r1_rdy = 1;
    t0 = A'(0); a0 = W'(100); b0 = W'(1);
    t1 = A'(1); a1 = W'(100); b1 = W'(1);
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
`ifdef ALU_ARB_RR_EN
      check("contend_req0_ready", W'(q0_rdy), W'((i % 2) == 0));
      check("contend_req1_ready", W'(q1_rdy), W'((i % 2) == 1));
`else
      check("contend_req0_ready", W'(q0_rdy), W'(1));
      check("contend_req1_ready", W'(q1_rdy), W'(0));
`endif
      tick();
      if (i > 0) check("contend_one_rsp", W'(s0_v ^ s1_v), W'(1));
    end

    // Randomized traffic.
    for (int unsigned n = 0; n < 3000; n++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      t0 = A'($urandom_range(0, 10));
      t1 = A'($urandom_range(0, 10));
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
      r0_rdy = ($urandom_range(0, 3) != 0);
      r1_rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0;
    idle_inputs();
    r0_rdy = 1; r1_rdy = 1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The module SHALL expose: i_sys_clk  input  1  single clock; all state changes on its rising edge.
REQ-002 The module SHALL expose: i_sys_rst  input  1  reset, synchronous and active-high.
REQ-003 The module SHALL expose: i_req0_valid / o_req0_ready  in/out  1  EXU-issue request handshake.
REQ-004 The module SHALL expose: i_req0_alu_type  in  `ARGS_WIDTH, and i_req0_rs1_data / i_req0_rs2_data  in  `DATA_WIDTH each, as the requester-0 operands.
REQ-005 The module SHALL expose: i_req1_valid, o_req1_ready, i_req1_alu_type, i_req1_rs1_data and i_req1_rs2_data, identical to REQ-003/004, for the secondary requester (address generation).
REQ-006 The module SHALL expose: o_rsp0_valid / i_rsp0_ready  out/in  1  requester-0 response handshake; o_rsp0_res  out  `DATA_WIDTH  result.
REQ-007 The module SHALL expose: o_rsp1_valid, i_rsp1_ready and o_rsp1_res, identical to REQ-006, for requester 1.
REQ-008 The module SHALL expose: o_arb_busy  out  1  response register occupied.

Function
REQ-009 The arbiter SHALL have states IDLE (no result held) and HOLD (one registered result pending delivery).
REQ-010 A request is accepted when valid && ready; at most one request SHALL be accepted per cycle.
REQ-011 The arbiter SHALL assert o_reqN_ready only for the granted requester, and only when the state is IDLE or a response handshake completes in the same cycle (back-to-back issue).
REQ-012 Grant, when only one requester is valid, SHALL go to that requester.
REQ-013 Grant, when both requesters are valid, SHALL follow the policy in REQ-024/025.
REQ-014 On accept, the accepted operands SHALL drive the shared alu instance, and its result SHALL be registered together with a 1-bit owner id; the state then becomes HOLD.
REQ-015 Latency: the response SHALL be valid exactly one cycle after the accept.
REQ-016 In HOLD, o_rspN_valid SHALL be high only for the owner, and the result and valid SHALL remain stable until the owner's i_rspN_ready is high.
REQ-017 On response handshake without a new accept, the state SHALL return to IDLE, and o_rspN_valid and o_rspN_res SHALL drop to 0 the next cycle.
REQ-018 On simultaneous response handshake and new accept, the state SHALL stay HOLD, with the new result and owner loaded.
REQ-019 Responses SHALL be delivered in accept order; no result may be dropped or duplicated.
REQ-020 o_arb_busy SHALL equal (state == HOLD).
REQ-021 An i_rspN_ready from the non-owner SHALL be ignored.

Reset
REQ-022 When i_sys_rst is high at a clock edge, the arbiter SHALL set the state to IDLE, all o_rsp*_valid to 0, all o_rsp*_res to 0, and the owner to 0.
REQ-023 Reset mid-HOLD SHALL discard the pending result, and ready outputs SHALL follow IDLE rules from the first cycle after reset.

Configuration
REQ-024 With macro ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: a last-grant pointer, reset to 1 so that requester 0 wins first, updates on every accept; on contention the arbiter SHALL grant the requester not last granted.
REQ-025 With ALU_ARB_RR_EN undefined, arbitration SHALL be fixed priority with requester 0 always winning contention, and no pointer flop SHALL exist.

Structure
REQ-026 The state enum (IDLE, HOLD) and the requester-id typedef SHALL live in shared package alu_arb_pkg, and the existing `DATA_WIDTH/`ARGS_WIDTH/`DATA_ZERO macros SHALL be reused.
REQ-027 The design SHALL contain exactly one sub-module: the existing combinational alu, instantiated once and muxed by the grant.

Verification
REQ-028 Scenario: req0 alone with ADD, rs1=0x0000_0005, rs2=0x0000_0003, rsp0_ready=1 -> cycle+1: rsp0_valid=1, res=0x0000_0008, rsp1_valid=0.
REQ-029 Scenario: both valid every cycle, rsp ready tied high, RR_EN defined -> grants 0,1,0,1 on consecutive cycles, one response per cycle.
REQ-030 Scenario: same as REQ-029 with RR_EN undefined -> req0 granted every cycle, req1_ready stays 0.
REQ-031 Scenario: req1 SUB 0x10-0x01 accepted, i_rsp1_ready held low 3 cycles -> o_rsp1_res=0x0000_000F stable, both req readies 0, o_arb_busy=1 throughout; release -> readies return.
REQ-032 Scenario: i_sys_rst pulsed while HOLD -> next cycle rsp valids 0, results 0, busy 0; a subsequent contended request grants requester 0.
REQ-033 Scenario: i_rsp0_ready pulsed while owner is req1 -> no handshake, result held.
